sprite_cmd_dispatcher: RTL

Upstream stage of the sprite display blocks (block, pipe, mario, enemy, etc.). It accepts 32-bit command words from the HPS over Avalon-MM and buffers them in a FIFO. It replays them onto a shared broadcast bus that every display block samples each clock as its writedata. Buffer-swap commands (action 4'hF) are held back until vertical blanking, so the displayed buffer only flips between frames.

---
 rtl/sprite_cmd_dispatcher.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sprite_cmd_dispatcher.sv
// Command FIFO and broadcast dispatcher for the sprite display blocks.
// Buffer-swap commands are held at the FIFO head until vertical blanking, at most one per blank.
module sprite_cmd_dispatcher #(
  parameter int FIFO_DEPTH = 64,
  parameter int VACTIVE    = 480,
  parameter int LVL_W      = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        swap_irq
);

  localparam int PTR_W = LVL_W - 1;

  typedef enum logic {ISSUE = 1'b0, HOLD = 1'b1} state_t;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             swapped_this_blank;
  logic [31:0]      frame_count;
  state_t           state, state_d;

  logic        wr_en, push_req, ovf_clr, flush, do_push;
  logic        empty, full, is_swap, swap_pending, in_blank, swap_ok;
  logic [31:0] head;
  logic        pop, issue_swap, irq_d;
  logic [31:0] cmd_d;
  logic        unused_hcount;

  assign unused_hcount = ^hcount;

  assign wr_en    = chipselect & write;
  assign push_req = wr_en & (address == 2'd0);
  assign ovf_clr  = wr_en & (address == 2'd2);
  assign flush    = wr_en & (address == 2'd3);

  assign empty        = (level == '0);
  assign full         = (level == LVL_W'(FIFO_DEPTH));
  assign head         = mem[rd_ptr];
  assign is_swap      = (head[20:17] == 4'hF);
  assign swap_pending = !empty & is_swap;
  assign in_blank     = (vcount >= 10'(VACTIVE));
  assign swap_ok      = in_blank & !swapped_this_blank;
  // A push onto a full FIFO is dropped even when a pop frees a slot on the same edge.
  assign do_push      = push_req & !full & !flush;

  always_ff @(posedge clk) begin
    if (reset) state <= ISSUE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (flush) begin
      state_d = ISSUE;
    end else begin
      case (state)
        ISSUE: if (swap_pending && !swap_ok) state_d = HOLD;
        HOLD:  if (empty || swap_ok)         state_d = ISSUE;
        default: state_d = ISSUE;
      endcase
    end
  end

  // HOLD only ever has a swap at the head, so the swap rule is shared by both states.
  always_comb begin
    pop        = 1'b0;
    issue_swap = 1'b0;
    irq_d      = 1'b0;
    cmd_d      = '0;
    if (!flush && !empty) begin
      if (!is_swap && state == ISSUE) begin
        pop   = 1'b1;
        cmd_d = head;
      end else if (is_swap && swap_ok) begin
        pop        = 1'b1;
        issue_swap = 1'b1;
        irq_d      = 1'b1;
        cmd_d      = head;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      level              <= '0;
      overflow           <= 1'b0;
      swapped_this_blank <= 1'b0;
      frame_count        <= '0;
      cmd_out            <= '0;
      swap_irq           <= 1'b0;
    end else begin
      cmd_out  <= cmd_d;
      swap_irq <= irq_d;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (do_push && !pop)      level <= level + 1'b1;
        else if (!do_push && pop) level <= level - 1'b1;
      end
      if (push_req && full) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
      if (issue_swap) begin
        swapped_this_blank <= 1'b1;
        frame_count        <= frame_count + 1'b1;
      end else if (!in_blank) begin
        swapped_this_blank <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= writedata;
  end

  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      case (address)
        2'd0: begin
          readdata[31]        = overflow;
          readdata[30]        = swap_pending;
          readdata[LVL_W-1:0] = level;
        end
        2'd1:    readdata = frame_count;
        default: readdata = '0;
      endcase
    end
  end

endmodule
